// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the arbiter and the single-ported memory.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface rv32i_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [MASK_W-1:0] d_wmask;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [MASK_W-1:0] mem_wmask;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_wmask, d_address, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_wmask, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Tie policy: data wins by default; define ARB_ROUND_ROBIN_EN to alternate grants.
module rv32i_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_mem_arbiter_if.slave  bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [MASK_W-1:0] r_mem_wmask;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_i_resp;
    logic w_d_resp;

    assign w_i_req = bus.i_read;
    assign w_d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recent grant went to data; resets to data so the first tie goes to fetch.
    logic r_last_d;

    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_d <= 1'b1;
        else if (r_state == IDLE && (w_i_req || w_d_req))
            r_last_d <= w_grant_d;
    end
`else
    assign w_grant_d = w_d_req;
`endif

    assign w_grant_i = w_i_req & ~w_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_i_resp = 1'b0;
        w_d_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_d)
                    w_next = SERVE_D;
                else if (w_grant_i)
                    w_next = SERVE_I;
            end
            SERVE_I: begin
                w_i_resp = bus.mem_resp;
                if (bus.mem_resp)
                    w_next = IDLE;
            end
            SERVE_D: begin
                w_d_resp = bus.mem_resp;
                if (bus.mem_resp)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The command is latched at grant so requester changes mid-access cannot disturb memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_wmask   <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_mem_read    <= ~bus.d_write;
                r_mem_write   <= bus.d_write;
                r_mem_wmask   <= bus.d_write ? bus.d_wmask : '0;
                r_mem_address <= bus.d_address;
                r_mem_wdata   <= bus.d_wdata;
            end else if (w_grant_i) begin
                r_mem_read    <= 1'b1;
                r_mem_write   <= 1'b0;
                r_mem_wmask   <= '0;
                r_mem_address <= bus.i_address;
                r_mem_wdata   <= '0;
            end
        end else if (bus.mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wmask <= '0;
        end
    end

    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_wmask   = r_mem_wmask;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.i_resp      = w_i_resp;
    assign bus.d_resp      = w_d_resp;
    assign bus.i_rdata     = bus.mem_rdata;
    assign bus.d_rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed cases with literal expectations, then random
// requesters and memory checked every cycle against a transaction-level model.
module tb_rv32i_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // memory side: scripted (man_*) or an automatic responder with random latency
    logic        auto_mem = 1'b0;
    logic        spur_en  = 1'b0;
    logic        man_resp = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        a_resp = 1'b0;
    logic [31:0] a_rdata = '0;
    int          a_cnt = 0;

    assign bus.mem_resp  = auto_mem ? a_resp  : man_resp;
    assign bus.mem_rdata = auto_mem ? a_rdata : man_rdata;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            a_resp <= 1'b0;
            a_cnt  <= 0;
        end else if (a_resp) begin
            a_resp <= 1'b0;
        end else if (a_cnt > 0) begin
            if (a_cnt == 1) begin
                a_resp  <= 1'b1;
                a_rdata <= $urandom;
            end
            a_cnt <= a_cnt - 1;
        end else if (bus.mem_read || bus.mem_write) begin
            a_cnt <= $urandom_range(1, 4);
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            a_resp  <= 1'b1;
            a_rdata <= $urandom;
        end
    end

    // Reference model: one outstanding access at a time, chosen from whoever is requesting
    logic        m_busy = 1'b0;
    logic        m_own_d = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_mask = '0;
    logic        m_last_d = 1'b1;

    wire t_dq = bus.d_read | bus.d_write;
    wire t_iq = bus.i_read;
`ifdef ARB_ROUND_ROBIN_EN
    wire t_tie_d = ~m_last_d;
`else
    wire t_tie_d = 1'b1;
`endif
    wire t_pick_d = t_dq & (~t_iq | t_tie_d);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_last_d <= 1'b1;
        end else if (m_busy) begin
            if (bus.mem_resp) m_busy <= 1'b0;
        end else if (t_dq || t_iq) begin
            m_busy   <= 1'b1;
            m_own_d  <= t_pick_d;
            m_last_d <= t_pick_d;
            m_wr     <= t_pick_d & bus.d_write;
            m_addr   <= t_pick_d ? bus.d_address : bus.i_address;
            m_wdata  <= bus.d_wdata;
            m_mask   <= (t_pick_d & bus.d_write) ? bus.d_wmask : 4'h0;
        end
    end

    // grant log: address of every newly issued memory command
    logic [31:0] glog[$];
    logic        prev_cmd = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                chk("rst_mem_read",    bus.mem_read,    0);
                chk("rst_mem_write",   bus.mem_write,   0);
                chk("rst_mem_wmask",   bus.mem_wmask,   0);
                chk("rst_mem_address", bus.mem_address, 0);
                chk("rst_mem_wdata",   bus.mem_wdata,   0);
                chk("rst_i_resp",      bus.i_resp,      0);
                chk("rst_d_resp",      bus.d_resp,      0);
            end else begin
                chk("mem_read",  bus.mem_read,  m_busy && !m_wr);
                chk("mem_write", bus.mem_write, m_busy && m_wr);
                chk("mem_wmask", bus.mem_wmask, m_busy ? m_mask : 4'h0);
                if (m_busy) chk("mem_address", bus.mem_address, m_addr);
                if (m_busy && m_wr) chk("mem_wdata", bus.mem_wdata, m_wdata);
                chk("i_resp", bus.i_resp, m_busy && !m_own_d && bus.mem_resp);
                chk("d_resp", bus.d_resp, m_busy && m_own_d && bus.mem_resp);
                if (bus.i_resp) chk("i_rdata", bus.i_rdata, bus.mem_rdata);
                if (bus.d_resp) chk("d_rdata", bus.d_rdata, bus.mem_rdata);
            end
            if ((bus.mem_read || bus.mem_write) && !prev_cmd) glog.push_back(bus.mem_address);
        end
        prev_cmd <= bus.mem_read | bus.mem_write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic chk_log(input int k, input logic [31:0] exp);
        if (glog.size() > k) chk("grant_order", glog[k], exp);
        else begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_order: entry %0d missing, expected %h", k, exp);
        end
    endtask

    task automatic i_access(input logic [31:0] addr);
        bit got = 0;
        bus.i_read    = 1'b1;
        bus.i_address = addr;
        for (int c = 0; c < 60 && !got; c++) begin
            nedge();
            if (bus.i_resp) got = 1;
        end
        tick();
        bus.i_read = 1'b0;
        chk("i_access_done", got, 1);
    endtask

    task automatic d_read_access(input logic [31:0] addr);
        bit got = 0;
        bus.d_read    = 1'b1;
        bus.d_address = addr;
        for (int c = 0; c < 60 && !got; c++) begin
            nedge();
            if (bus.d_resp) got = 1;
        end
        tick();
        bus.d_read = 1'b0;
        chk("d_access_done", got, 1);
    endtask

    task automatic i_rand(input int n);
        bit seen;
        for (int c = 0; c < n; c++) begin
            nedge();
            seen = bus.i_resp;
            tick();
            if (bus.i_read) begin
                if (seen) begin
                    if ($urandom_range(0, 2) == 0) bus.i_address = $urandom;
                    else bus.i_read = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.i_read    = 1'b1;
                bus.i_address = $urandom;
            end
        end
        bus.i_read = 1'b0;
    endtask

    task automatic d_rand(input int n);
        bit seen;
        int op;
        for (int c = 0; c < n; c++) begin
            nedge();
            seen = bus.d_resp;
            tick();
            if (bus.d_read || bus.d_write) begin
                if (seen) begin
                    bus.d_read  = 1'b0;
                    bus.d_write = 1'b0;
                end else if ($urandom_range(0, 4) == 0) begin
                    bus.d_address = $urandom;
                    bus.d_wdata   = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                op = $urandom_range(0, 2);
                bus.d_read    = (op != 1);
                bus.d_write   = (op != 0);
                bus.d_address = $urandom;
                bus.d_wdata   = $urandom;
                bus.d_wmask   = 4'($urandom);
            end
        end
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    initial begin
        bus.i_read = 1'b0;  bus.i_address = '0;
        bus.d_read = 1'b0;  bus.d_write = 1'b0;  bus.d_wmask = '0;
        bus.d_address = '0; bus.d_wdata = '0;
        started = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        nedge();
        chk("idle_mem_read", bus.mem_read, 0);
        tick();

        // instruction read, memory answers after 3 cycles
        bus.i_read = 1'b1; bus.i_address = 32'h60;
        tick();
        nedge();
        chk("t1_mem_read", bus.mem_read, 1);
        chk("t1_mem_address", bus.mem_address, 32'h60);
        tick(); tick();
        man_resp = 1'b1; man_rdata = 32'h0000_0013;
        nedge();
        chk("t1_i_resp", bus.i_resp, 1);
        chk("t1_i_rdata", bus.i_rdata, 32'h0000_0013);
        chk("t1_d_resp", bus.d_resp, 0);
        tick();
        man_resp = 1'b0; bus.i_read = 1'b0;
        nedge();
        chk("t1_i_resp_pulse", bus.i_resp, 0);
        chk("t1_mem_read_clr", bus.mem_read, 0);
        tick();

        // data write with partial byte mask
        bus.d_write = 1'b1; bus.d_address = 32'h104;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'b0011;
        tick();
        nedge();
        chk("t2_mem_write", bus.mem_write, 1);
        chk("t2_mem_wmask", bus.mem_wmask, 4'b0011);
        chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_address", bus.mem_address, 32'h104);
        tick();
        man_resp = 1'b1;
        nedge();
        chk("t2_d_resp", bus.d_resp, 1);
        chk("t2_i_resp", bus.i_resp, 0);
        tick();
        man_resp = 1'b0; bus.d_write = 1'b0;
        nedge();
        chk("t2_d_resp_pulse", bus.d_resp, 0);
        chk("t2_wmask_clr", bus.mem_wmask, 0);
        tick();

        // simultaneous requests, a lone fetch, then another tie
        auto_mem = 1'b1;
        glog.delete();
        fork
            i_access(32'h1000);
            d_read_access(32'h2000);
        join
        i_access(32'h3000);
        fork
            i_access(32'h1000);
            d_read_access(32'h2000);
        join
`ifdef ARB_ROUND_ROBIN_EN
        chk_log(0, 32'h1000);
        chk_log(1, 32'h2000);
`else
        chk_log(0, 32'h2000);
        chk_log(1, 32'h1000);
`endif
        chk_log(2, 32'h3000);
        chk_log(3, 32'h2000);
        chk_log(4, 32'h1000);
        tick();

        // asynchronous reset during a data write
        auto_mem = 1'b0;
        bus.d_write = 1'b1; bus.d_address = 32'h400; bus.d_wmask = 4'hF;
        tick();
        nedge();
        chk("t5_mem_write", bus.mem_write, 1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_async_write", bus.mem_write, 0);
        chk("t5_async_wmask", bus.mem_wmask, 0);
        #3 rst = 1'b0; bus.d_write = 1'b0;
        tick(); tick();
        man_resp = 1'b1;
        nedge();
        chk("t5_late_d_resp", bus.d_resp, 0);
        chk("t5_late_i_resp", bus.i_resp, 0);
        tick();
        man_resp = 1'b0;
        auto_mem = 1'b1;
        glog.delete();
        i_access(32'h500);
        chk_log(0, 32'h500);
        tick();

        // spurious response in IDLE, address change mid-grant
        auto_mem = 1'b0;
        man_resp = 1'b1;
        nedge();
        chk("t6_spur_i", bus.i_resp, 0);
        chk("t6_spur_d", bus.d_resp, 0);
        tick();
        man_resp = 1'b0;
        bus.d_read = 1'b1; bus.d_address = 32'h200;
        tick();
        nedge();
        chk("t6_mem_read", bus.mem_read, 1);
        tick();
        bus.d_address = 32'h300;
        nedge();
        chk("t6_addr_held", bus.mem_address, 32'h200);
        tick();
        man_resp = 1'b1;
        nedge();
        chk("t6_d_resp", bus.d_resp, 1);
        chk("t6_addr_at_resp", bus.mem_address, 32'h200);
        tick();
        man_resp = 1'b0; bus.d_read = 1'b0;
        tick();

        // random traffic
        auto_mem = 1'b1;
        spur_en  = 1'b1;
        fork
            i_rand(3000);
            d_rand(3000);
        join
        spur_en = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
Arbitrates one shared single-ported memory between the instruction-fetch requester and the load/store requester of the multicycle RV32I core. It latches the winning request, drives it onto the memory port until mem_resp, and returns the response to the owner. It sits between the core's fetch/MDR logic and physical memory, so that fetch and data accesses never collide.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports; must be a multiple of 8
MASK_W, DATA_W/8, byte-enable width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
i_read  in  1  instruction read request, held until i_resp
i_address  in  ADDR_W  instruction address
i_rdata  out  DATA_W  instruction read data, valid while i_resp=1
i_resp  out  1  instruction access done, 1-cycle pulse
d_read  in  1  data read request, held until d_resp
d_write  in  1  data write request, held until d_resp
d_wmask  in  MASK_W  byte enables for d_write
d_address  in  ADDR_W  data address
d_wdata  in  DATA_W  data write value
d_rdata  out  DATA_W  data read value, valid while d_resp=1
d_resp  out  1  data access done, 1-cycle pulse
mem_read  out  1  memory read command
mem_write  out  1  memory write command
mem_wmask  out  MASK_W  memory byte enables
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_resp
mem_resp  in  1  memory done, 1-cycle pulse

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Reset state: IDLE.
- Reset values: mem_read=0, mem_write=0, mem_wmask=0, mem_address=0, mem_wdata=0; i_resp=0, d_resp=0.
- IDLE: sample requests. d_req = d_read|d_write. If exactly one requester is active, grant it. If both are active, apply the priority rule (see Optional Feature). On a grant edge, register the address, wdata, wmask and op into the mem_* output registers; mem_wmask=0 for reads.
- Latency: request seen at edge N; mem_read/mem_write are asserted from cycle N+1. The IDLE cycle is the arbitration cycle.
- If d_read and d_write are both 1: treat the access as a write.
- SERVE_x: hold mem_* outputs constant until mem_resp=1. In that cycle:
  - x_resp = 1 combinationally (x_resp = mem_resp & state==SERVE_x).
  - x_rdata = mem_rdata (pass-through; i_rdata/d_rdata always equal mem_rdata).
  - At the next edge: go to IDLE, clear mem_read, mem_write and mem_wmask.
- Turnaround: one IDLE cycle between consecutive grants, minimum. Back-to-back accesses therefore take the memory latency plus 2 cycles each.
- The owner drops its request in the cycle after x_resp. The IDLE sample at that edge sees either the dropped request or a new one; either is legal.
- mem_resp while in IDLE: ignored. No x_resp, no state change.
- Requester changes address or data mid-grant: no effect, because the values are latched.
- A requester that drops its request before its resp is a protocol violation. The grant still completes.
- rst asserted mid-transaction: immediately return to IDLE and drive all outputs to their reset values, with no clock required. A later mem_resp is ignored.
- The non-owner never sees resp=1.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: a register last_grant is updated on every grant; its reset value is DATA. On a tie in IDLE, grant the requester not in last_grant, so the first tie after reset goes to instruction.
- Undefined: fixed priority, data over instruction, on every tie. No last_grant register exists.
- All other behaviour is identical in both builds.

Test Plan:
- Instruction read only: i_read=1, i_address=0x60, memory answers 0x00000013 after 3 cycles -> mem_read=1 with mem_address=0x60 from cycle 1; i_resp=1 with i_rdata=0x00000013 for exactly 1 cycle; d_resp stays 0.
- Data write: d_write=1, d_address=0x104, d_wdata=0xDEADBEEF, d_wmask=4'b0011 -> mem_write=1 with mem_wmask=0011, mem_wdata=0xDEADBEEF; d_resp pulses once; then IDLE with mem_wmask=0.
- Simultaneous i_read and d_read at the same edge, macro undefined -> data served first; instruction granted after the IDLE turnaround. Repeat twice -> data wins both times.
- Same stimulus with ARB_ROUND_ROBIN_EN -> order is I, D on the first tie and D, I on the second (grants alternate).
- rst pulsed while in SERVE_D before mem_resp -> mem_write=0 asynchronously. A mem_resp 2 cycles later produces no d_resp. A fresh i_read is then served normally.
- Spurious mem_resp in IDLE, plus d_address changed from 0x200 to 0x300 during SERVE_D -> no resp pulse in IDLE; mem_address stays 0x200 until d_resp.
